apb_controller: RTL and testbench
=================================

# apb_controller

Sequencing FSM of the AHB-to-APB bridge. It sits between `ahb_slave` (which decodes `valid` and `TEMP_SEL`) and the APB bus. It accepts qualified AHB transfers, drives APB SETUP/ENABLE phases on `PSELx`/`PENABLE`/`PADDR`/`PWDATA`/`PWRITE`, and stretches the AHB data phase through `HREADYout`. It runs one APB transfer at a time with no write posting. `HRDATA` remains a pass-through of `PRDATA` inside `ahb_slave`.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width

Ports:
- `HCLK`  in  1  bridge clock; single clock domain
- `HRESETn`  in  1  reset, synchronous, active-low
- `valid`  in  1  address in bridge range (from `ahb_slave`)
- `HTRANS`  in  2  AHB transfer type
- `HREADYin`  in  1  AHB bus ready
- `HWRITE`  in  1  AHB direction
- `HADDR`  in  AW  AHB address
- `HWDATA`  in  DW  AHB write data
- `TEMP_SEL`  in  3  one-hot peripheral select (from `ahb_slave`)
- `PSELx`  out  3  APB select, one-hot or zero
- `PENABLE`  out  1  APB enable
- `PWRITE`  out  1  APB direction
- `PADDR`  out  AW  APB address
- `PWDATA`  out  DW  APB write data
- `HREADYout`  out  1  bridge ready to AHB

## Operation
- `accept = valid & HTRANS[1] & HREADYin`. Only NONSEQ and SEQ transfers are accepted; IDLE and BUSY are ignored.
- `accept` is evaluated only in `ST_IDLE`, `ST_RENABLE` and `ST_WENABLE`. These are the only states with `HREADYout = 1`.
- On accept, the block latches `HADDR`→`addr_q`, `TEMP_SEL`→`sel_q` and `HWRITE`→`write_q`.
- All outputs are registered and are assigned on entry to a state.
- State transitions:
  - `ST_IDLE`: on accept & ~HWRITE → `ST_RSETUP`; on accept & HWRITE → `ST_WWAIT`; otherwise stay.
  - `ST_RSETUP` → `ST_RENABLE`. On entry: `PSELx=TEMP_SEL`, `PADDR=HADDR`, `PWRITE=0`, `PENABLE=0`, `HREADYout=0`.
  - `ST_RENABLE`: on entry `PENABLE=1`, `HREADYout=1`. `PRDATA` is sampled by the master this cycle. Next state: accept & read → `ST_RSETUP`; accept & write → `ST_WWAIT`; otherwise `ST_IDLE`.
  - `ST_WWAIT` → `ST_WSETUP`. On entry: `PSELx=0`, `PENABLE=0`, `HREADYout=0`. The master holds `HWDATA` valid during this cycle.
  - `ST_WSETUP` → `ST_WENABLE`. On entry: `PSELx=sel_q`, `PADDR=addr_q`, `PWDATA=HWDATA`, `PWRITE=1`, `PENABLE=0`, `HREADYout=0`.
  - `ST_WENABLE`: on entry `PENABLE=1`, `HREADYout=1`. Next state is chosen exactly as in `ST_RENABLE`.
- On exit to `ST_IDLE`: `PSELx=0`, `PENABLE=0`. `PADDR`, `PWDATA` and `PWRITE` hold their last values.
- An accepted transfer with `TEMP_SEL=3'b000` still sequences normally with `PSELx=0`. No slave responds and the read data is undefined.

## Timing
- Reset: at any `HCLK` edge with `HRESETn=0`, the block goes to `ST_IDLE` and sets `PSELx=0`, `PENABLE=0`, `PWRITE=0`, `PADDR=0`, `PWDATA=0`, `HREADYout=1`.
- Reset mid-transfer aborts the transfer. No ENABLE phase is issued after reset deasserts.
- Read: accept at edge E0 → SETUP during E0–E1 → ENABLE during E1–E2, with `HREADYout=1` in E1–E2. This is one AHB wait state.
- Write: accept at E0 → WWAIT in E0–E1 → SETUP in E1–E2 (`PWDATA` valid) → ENABLE in E2–E3, with `HREADYout=1` in E2–E3. This is two AHB wait states.
- Back-to-back: an accept in an ENABLE cycle goes directly to the next SETUP (read) or WWAIT (write). There is no IDLE cycle in between.
- `PENABLE` is never high for two consecutive cycles. `PENABLE=1` always follows exactly one SETUP cycle with identical `PSELx`, `PADDR` and `PWRITE`.
- `PSELx` is stable across SETUP and the following ENABLE.
- No APB wait states: `PREADY` is not supported, so every ENABLE is a single cycle.

## Structure
- Shared package `apb_bridge_pkg` holds:
  - the state enum: `ST_IDLE`, `ST_WWAIT`, `ST_RSETUP`, `ST_RENABLE`, `ST_WSETUP`, `ST_WENABLE`;
  - the `HTRANS` encodings `IDLE`, `BUSY`, `NONSEQ`, `SEQ`;
  - the `TEMP_SEL` one-hot constants `SEL_P0=3'b001`, `SEL_P1=3'b010`, `SEL_P2=3'b100`.
- Single module with no sub-module: one state register, one next-state block and one registered output block.
- The top level wires `HREADYout` back to `HREADYin` in single-slave configurations.

## Test plan
- **Reset mid-write:** hold `HRESETn=0` for 2 edges while in `ST_WSETUP`. Required: next cycle has `PSELx=0`, `PENABLE=0`, `PADDR=0`, `HREADYout=1`, and no ENABLE follows.
- **Single read:** NONSEQ read at `HADDR=32'h8000_0010` with `TEMP_SEL=001`. Required: one SETUP cycle with `PADDR=32'h8000_0010`, `PSELx=001`, `PENABLE=0`; then one ENABLE cycle with `PENABLE=1`, `HREADYout=1`; then IDLE.
- **Single write:** NONSEQ write at `32'h8800_0004`, `HWDATA=32'hDEAD_BEEF`, `TEMP_SEL=010`. Required: `HREADYout` low for 2 cycles; SETUP with `PWDATA=32'hDEAD_BEEF`, `PWRITE=1`, `PSELx=010`; then ENABLE.
- **Back-to-back read→write→read:** reads at `32'h8400_0000` / `32'h8400_0008`, write at `32'h8400_0004`. Required: no IDLE cycles between transfers, and `PADDR` sequence `8400_0000`, `8400_0004`, `8400_0008`.
- **Non-accepted transfers:** `HTRANS=BUSY` with `valid=1`, or `HTRANS=NONSEQ` with `valid=0` (`HADDR=32'h9000_0000`). Required: state stays `ST_IDLE`, `PSELx=0`, `HREADYout=1`.
- **ENABLE/SETUP invariant:** random legal AHB traffic, 10k cycles. Assert that every `PENABLE=1` cycle is preceded by SETUP with matching `PSELx`/`PADDR`, and that `PENABLE` is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared types and encodings for the AHB-to-APB bridge: FSM states, HTRANS
// codes and peripheral select constants.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WWAIT   = 3'd1,
    ST_RSETUP  = 3'd2,
    ST_RENABLE = 3'd3,
    ST_WSETUP  = 3'd4,
    ST_WENABLE = 3'd5
  } state_e;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic [2:0] SEL_P0 = 3'b001;
  localparam logic [2:0] SEL_P1 = 3'b010;
  localparam logic [2:0] SEL_P2 = 3'b100;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are ignored.
  function automatic logic is_active_trans(input logic [1:0] htrans);
    return (htrans == NONSEQ) || (htrans == SEQ);
  endfunction

endpackage

// File: rtl/apb_controller_if.sv
// AHB-side qualified transfer inputs and APB-side outputs of the bridge
// sequencer. The slave modport is the controller's view.
interface apb_controller_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          valid;
  logic [1:0]    HTRANS;
  logic          HREADYin;
  logic          HWRITE;
  logic [AW-1:0] HADDR;
  logic [DW-1:0] HWDATA;
  logic [2:0]    TEMP_SEL;

  logic [2:0]    PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          HREADYout;

  modport slave (
    input  valid, HTRANS, HREADYin, HWRITE, HADDR, HWDATA, TEMP_SEL,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA, HREADYout
  );

  modport master (
    output valid, HTRANS, HREADYin, HWRITE, HADDR, HWDATA, TEMP_SEL,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, HREADYout
  );

endinterface

// File: rtl/apb_controller.sv
// Sequencing FSM of the AHB-to-APB bridge: one APB transfer at a time, read
// in SETUP/ENABLE, write via a wait cycle to capture HWDATA, then SETUP/ENABLE.
module apb_controller
  import apb_bridge_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  apb_controller_if.slave   bus
);

  state_e        r_state;
  state_e        w_next_state;
  logic          w_accept_window;
  logic          w_accept;

  logic [AW-1:0] r_addr_q;
  logic [2:0]    r_sel_q;
  logic          r_write_q;

  logic [2:0]    r_psel;
  logic          r_penable;
  logic          r_pwrite;
  logic [AW-1:0] r_paddr;
  logic [DW-1:0] r_pwdata;
  logic          r_hready;

  // A new transfer is only taken while the bridge is showing HREADYout=1.
  assign w_accept_window = (r_state == ST_IDLE) || (r_state == ST_RENABLE) ||
                           (r_state == ST_WENABLE);
  assign w_accept        = w_accept_window & bus.valid &
                           is_active_trans(bus.HTRANS) & bus.HREADYin;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (w_accept) w_next_state = bus.HWRITE ? ST_WWAIT : ST_RSETUP;
        else          w_next_state = ST_IDLE;
      end
      ST_RSETUP: w_next_state = ST_RENABLE;
      ST_WWAIT:  w_next_state = ST_WSETUP;
      ST_WSETUP: w_next_state = ST_WENABLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Outputs take their values on entry to the state chosen for the next cycle.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_addr_q  <= '0;
      r_sel_q   <= '0;
      r_write_q <= 1'b0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_hready  <= 1'b1;
    end else begin
      if (w_accept) begin
        r_addr_q  <= bus.HADDR;
        r_sel_q   <= bus.TEMP_SEL;
        r_write_q <= bus.HWRITE;
      end
      case (w_next_state)
        ST_RSETUP: begin
          r_psel    <= bus.TEMP_SEL;
          r_paddr   <= bus.HADDR;
          r_pwrite  <= 1'b0;
          r_penable <= 1'b0;
          r_hready  <= 1'b0;
        end
        ST_RENABLE, ST_WENABLE: begin
          r_penable <= 1'b1;
          r_hready  <= 1'b1;
        end
        ST_WWAIT: begin
          r_psel    <= '0;
          r_penable <= 1'b0;
          r_hready  <= 1'b0;
        end
        ST_WSETUP: begin
          r_psel    <= r_sel_q;
          r_paddr   <= r_addr_q;
          r_pwdata  <= bus.HWDATA;
          r_pwrite  <= r_write_q;
          r_penable <= 1'b0;
          r_hready  <= 1'b0;
        end
        default: begin
          r_psel    <= '0;
          r_penable <= 1'b0;
          r_hready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.PSELx     = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.HREADYout = r_hready;

endmodule

// File: tb/tb_apb_controller.sv
// Bench for apb_controller: directed scenarios with literal expectations plus
// randomized AHB traffic checked cycle-by-cycle against a transaction schedule model.
module tb_apb_controller;
  import apb_bridge_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [2:0]    psel;
    logic          pen;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          hready;
  } frame_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  always #5 clk = ~clk;

  apb_controller_if #(.AW(AW), .DW(DW)) bus();
  assign bus.HREADYin = bus.HREADYout & ~stall;

  apb_controller #(.AW(AW), .DW(DW)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: expected output frame for the current cycle plus a
  // schedule of frames a just-accepted transfer will produce.
  frame_t cur;
  frame_t exp_q[$];
  bit     m_live = 1'b0;
  bit     m_cap  = 1'b0;
  frame_t f;
  logic   acc;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cur    = '{psel: 3'b000, pen: 1'b0, pwrite: 1'b0, paddr: '0, pwdata: '0, hready: 1'b1};
      m_live = 1'b1;
      m_cap  = 1'b0;
    end else if (m_live) begin
      if (m_cap) begin
        f = exp_q[0]; f.pwdata = bus.HWDATA; exp_q[0] = f;
        f = exp_q[1]; f.pwdata = bus.HWDATA; exp_q[1] = f;
        m_cap = 1'b0;
      end
      acc = cur.hready && bus.valid && bus.HREADYin &&
            (bus.HTRANS == NONSEQ || bus.HTRANS == SEQ);
      if (acc) begin
        if (!bus.HWRITE) begin
          f = '{psel: bus.TEMP_SEL, pen: 1'b0, pwrite: 1'b0, paddr: bus.HADDR,
                pwdata: cur.pwdata, hready: 1'b0};
          exp_q.push_back(f);
          f.pen = 1'b1; f.hready = 1'b1;
          exp_q.push_back(f);
        end else begin
          f = '{psel: 3'b000, pen: 1'b0, pwrite: cur.pwrite, paddr: cur.paddr,
                pwdata: cur.pwdata, hready: 1'b0};
          exp_q.push_back(f);
          f = '{psel: bus.TEMP_SEL, pen: 1'b0, pwrite: 1'b1, paddr: bus.HADDR,
                pwdata: '0, hready: 1'b0};
          exp_q.push_back(f);
          f.pen = 1'b1; f.hready = 1'b1;
          exp_q.push_back(f);
          m_cap = 1'b1;
        end
      end
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = '{psel: 3'b000, pen: 1'b0, pwrite: cur.pwrite, paddr: cur.paddr,
                   pwdata: cur.pwdata, hready: 1'b1};
    end
  end

  // Compare process: full frame against the model, plus the APB phase invariant.
  logic [2:0]    p_psel;
  logic          p_pen = 1'b0;
  logic          p_pwrite;
  logic [AW-1:0] p_paddr;
  bit            log_en = 1'b0;
  frame_t        log_q[$];

  always @(negedge clk) begin
    frame_t a;
    logic [$bits(frame_t)-1:0] av, ev;
    a = {bus.PSELx, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.HREADYout};
    if (m_live) begin
      av = a; ev = cur;
      n_cmp++;
      if (av !== ev) begin
        n_err++;
        $display("FAIL model_frame t=%0t: got %h expected %h", $time, av, ev);
      end
      if (bus.PENABLE === 1'b1) begin
        n_cmp++;
        if (p_pen !== 1'b0 || p_psel !== bus.PSELx || p_paddr !== bus.PADDR ||
            p_pwrite !== bus.PWRITE) begin
          n_err++;
          $display("FAIL enable_after_setup t=%0t: got prev pen=%b psel=%b paddr=%h pwrite=%b, expected pen=0 psel=%b paddr=%h pwrite=%b",
                   $time, p_pen, p_psel, p_paddr, p_pwrite, bus.PSELx, bus.PADDR, bus.PWRITE);
        end
      end
    end
    p_pen = bus.PENABLE; p_psel = bus.PSELx; p_paddr = bus.PADDR; p_pwrite = bus.PWRITE;
    if (log_en) log_q.push_back(a);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    bus.valid = 1'b0; bus.HTRANS = IDLE; bus.HWRITE = 1'b0;
    bus.HADDR = '0; bus.TEMP_SEL = 3'b000;
  endtask

  // Present an AHB address phase and return #1 after the edge that takes it.
  task automatic ahb(input logic w, input logic [AW-1:0] a, input logic [2:0] sel,
                     input logic [DW-1:0] d, input string nm);
    bit ok = 1'b0;
    bus.valid = 1'b1; bus.HTRANS = NONSEQ; bus.HWRITE = w;
    bus.HADDR = a; bus.TEMP_SEL = sel;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      ok = (bus.HREADYin === 1'b1);
      @(posedge clk); #1;
    end
    chk({nm, "_accepted"}, 64'(ok), 64'(1));
    drive_idle();
    bus.HWDATA = w ? d : $urandom;
  endtask

  initial begin
    int first_s, last_e, n_en;
    logic [AW-1:0] en_addr[$];
    int k;

    drive_idle();
    bus.HWDATA = '0;
    rst_n = 1'b0;
    repeat (2) step();
    chk("reset_psel",   64'(bus.PSELx),     64'(0));
    chk("reset_pen",    64'(bus.PENABLE),   64'(0));
    chk("reset_paddr",  64'(bus.PADDR),     64'(0));
    chk("reset_pwdata", 64'(bus.PWDATA),    64'(0));
    chk("reset_hready", 64'(bus.HREADYout), 64'(1));
    rst_n = 1'b1;
    step();

    // Single read
    ahb(1'b0, 32'h8000_0010, SEL_P0, '0, "rd");
    chk("rd_setup_paddr",  64'(bus.PADDR),     64'(32'h8000_0010));
    chk("rd_setup_psel",   64'(bus.PSELx),     64'(3'b001));
    chk("rd_setup_pen",    64'(bus.PENABLE),   64'(0));
    chk("rd_setup_hready", 64'(bus.HREADYout), 64'(0));
    step();
    chk("rd_enable_pen",    64'(bus.PENABLE),   64'(1));
    chk("rd_enable_hready", 64'(bus.HREADYout), 64'(1));
    chk("rd_enable_psel",   64'(bus.PSELx),     64'(3'b001));
    step();
    chk("rd_idle_psel",   64'(bus.PSELx),     64'(0));
    chk("rd_idle_pen",    64'(bus.PENABLE),   64'(0));
    chk("rd_idle_hready", 64'(bus.HREADYout), 64'(1));

    // Single write
    ahb(1'b1, 32'h8800_0004, SEL_P1, 32'hDEAD_BEEF, "wr");
    chk("wr_wait_hready", 64'(bus.HREADYout), 64'(0));
    chk("wr_wait_psel",   64'(bus.PSELx),     64'(0));
    step();
    chk("wr_setup_hready", 64'(bus.HREADYout), 64'(0));
    chk("wr_setup_pwdata", 64'(bus.PWDATA),    64'(32'hDEAD_BEEF));
    chk("wr_setup_pwrite", 64'(bus.PWRITE),    64'(1));
    chk("wr_setup_psel",   64'(bus.PSELx),     64'(3'b010));
    chk("wr_setup_paddr",  64'(bus.PADDR),     64'(32'h8800_0004));
    chk("wr_setup_pen",    64'(bus.PENABLE),   64'(0));
    step();
    chk("wr_enable_pen",    64'(bus.PENABLE),   64'(1));
    chk("wr_enable_hready", 64'(bus.HREADYout), 64'(1));
    step();
    chk("wr_idle_psel", 64'(bus.PSELx), 64'(0));

    // Back-to-back read -> write -> read
    log_q.delete();
    log_en = 1'b1;
    ahb(1'b0, 32'h8400_0000, SEL_P2, '0, "b2b_r0");
    ahb(1'b1, 32'h8400_0004, SEL_P0, 32'h0BAD_F00D, "b2b_w");
    ahb(1'b0, 32'h8400_0008, SEL_P1, '0, "b2b_r1");
    repeat (3) step();
    log_en = 1'b0;
    first_s = -1; last_e = -1; n_en = 0;
    en_addr.delete();
    foreach (log_q[i]) begin
      if (first_s < 0 && log_q[i].psel != 3'b000 && !log_q[i].pen) first_s = i;
      if (log_q[i].pen) begin last_e = i; n_en++; en_addr.push_back(log_q[i].paddr); end
    end
    chk("b2b_span_cycles", 64'(last_e - first_s + 1), 64'(7));
    chk("b2b_enable_count", 64'(n_en), 64'(3));
    if (en_addr.size() == 3) begin
      chk("b2b_paddr0", 64'(en_addr[0]), 64'(32'h8400_0000));
      chk("b2b_paddr1", 64'(en_addr[1]), 64'(32'h8400_0004));
      chk("b2b_paddr2", 64'(en_addr[2]), 64'(32'h8400_0008));
    end

    // Non-accepted transfers
    bus.valid = 1'b1; bus.HTRANS = BUSY; bus.HADDR = 32'h8000_0040; bus.TEMP_SEL = SEL_P0;
    repeat (3) begin
      step();
      chk("na_busy_psel",   64'(bus.PSELx),     64'(0));
      chk("na_busy_hready", 64'(bus.HREADYout), 64'(1));
    end
    bus.valid = 1'b0; bus.HTRANS = NONSEQ; bus.HADDR = 32'h9000_0000;
    repeat (3) begin
      step();
      chk("na_invalid_psel",   64'(bus.PSELx),     64'(0));
      chk("na_invalid_hready", 64'(bus.HREADYout), 64'(1));
    end
    drive_idle();
    step();

    // Reset during write SETUP
    ahb(1'b1, 32'h8C00_0020, SEL_P2, 32'h1234_5678, "rstw");
    step();
    chk("rstw_setup_pwdata", 64'(bus.PWDATA), 64'(32'h1234_5678));
    rst_n = 1'b0;
    step();
    chk("rstw_psel",   64'(bus.PSELx),     64'(0));
    chk("rstw_pen",    64'(bus.PENABLE),   64'(0));
    chk("rstw_paddr",  64'(bus.PADDR),     64'(0));
    chk("rstw_hready", 64'(bus.HREADYout), 64'(1));
    step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      chk("rstw_no_enable", 64'(bus.PENABLE), 64'(0));
    end

    // Randomized AHB traffic
    for (int c = 0; c < 10000; c++) begin
      bus.valid  = ($urandom_range(0, 3) != 0);
      bus.HTRANS = 2'($urandom_range(0, 3));
      bus.HWRITE = 1'($urandom_range(0, 1));
      bus.HADDR  = $urandom;
      bus.HWDATA = $urandom;
      k = $urandom_range(0, 3);
      bus.TEMP_SEL = (k == 0) ? 3'b000 : 3'(1 << (k - 1));
      stall = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 1999) != 0);
      step();
    end
    drive_idle();
    stall = 1'b0;
    rst_n = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
